cordic_iter_engine: RTL and testbench
=====================================

Name: cordic_iter_engine

Overview:
- Parametrised, iterative (one micro-rotation per clock) CORDIC core with its own sequencer, datapath, arctan table and valid/ready handshakes.
- Supports rotation mode (rotate vector by angle) and vectoring mode (magnitude/phase), with quadrant pre-rotation for full-circle coverage.
- Successor to the fixed 32-count CORDIC sequencer; sits between operand producers (NCO, phase/magnitude requesters) and result consumers in the DSP subsystem.

Parameters:
- DATA_W, 16: width of signed x/y/z inputs; angle format is two's complement with 2^(DATA_W-1) = pi.
- ITERS, 16: number of micro-rotations. Legal range is 2..DATA_W.
- GUARD, 2: extra MSBs on the internal x/y datapath to absorb CORDIC gain (~1.647).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- abort  in  1  synchronous cancel of the current operation.
- in_valid  in  1  operand valid.
- in_ready  out  1  engine can accept an operand (IDLE only).
- in_mode  in  1  0 = rotation, 1 = vectoring.
- in_x, in_y, in_z  in  DATA_W each  signed operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_x, out_y  out  DATA_W+GUARD  signed results, not gain-compensated.
- out_z  out  DATA_W  signed residual/accumulated angle.
- busy  out  1  high in RUN or HOLD.
- iter_cnt  out  $clog2(ITERS)  current iteration index; 0 outside RUN.
- done  out  1  one-cycle pulse on the cycle out_valid first rises.

Behaviour:
- State machine: IDLE, RUN, HOLD.
- Reset: state=IDLE; iter_cnt=0; out_valid=0; done=0; busy=0; in_ready=1; out_x/out_y/out_z=0.
- rst has priority over abort; abort has priority over all other transitions.

IDLE:
- in_ready=1.
- On in_valid&&in_ready (cycle T), latch in_mode and sign-extend x/y to DATA_W+GUARD.
- Apply pre-rotation in the same cycle, then go to RUN with iter_cnt=0.

Pre-rotation, rotation mode (by z[DATA_W-1:DATA_W-2]):
- 01: (x,y) <= (-y,x); z -= 2^(DATA_W-2).
- 10: (x,y) <= (y,-x); z += 2^(DATA_W-2).
- Otherwise: unchanged.

Pre-rotation, vectoring mode (only if x<0):
- y>=0: (x,y) <= (y,-x); z += 2^(DATA_W-2).
- y<0: (x,y) <= (-y,x); z -= 2^(DATA_W-2).

RUN, iteration i = iter_cnt:
- Direction d: in rotation mode d = +1 if z>=0 else -1; in vectoring mode d = +1 if y<0 else -1.
- Update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i.
- All shifts are arithmetic; all adds wrap modulo width; z wraps modulo 2pi.
- After iteration ITERS-1 (cycle T+ITERS), go to HOLD: out_valid=1, done=1 for one cycle, outputs registered.
- Latency: out_valid first high at T+ITERS+1.

HOLD:
- Outputs stable while out_valid && !out_ready.
- On out_valid&&out_ready: out_valid=0 and go to IDLE; in_ready=1 on the next cycle. There is no same-cycle re-accept.

abort:
- From RUN or HOLD: next cycle IDLE, out_valid=0, iter_cnt=0, no done pulse, result discarded.
- In IDLE: no effect, and any same-cycle in_valid is ignored.

Other rules:
- in_valid asserted during RUN/HOLD is ignored; the producer must hold it until in_ready.
- atan_i = round(atan(2^-i)/pi * 2^(DATA_W-1)). For DATA_W=16: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.

Decomposition:
- Package cordic_pkg holds:
  - state enum cordic_state_t {IDLE, RUN, HOLD};
  - mode constants MODE_ROT=0, MODE_VEC=1;
  - a constant function computing atan_i for any DATA_W/i.
- Sub-module cordic_atan_rom: parametrised combinational table indexed by iter_cnt returning atan_i (DATA_W wide).
- Sequencer and datapath stay in cordic_iter_engine.

Test Plan:
- Rotation in_x=19898, in_y=0, in_z=8192 (pi/4):
  - out_x=23170±4, out_y=23170±4, out_z=0±2;
  - out_valid exactly 17 cycles after accept; done pulses once.
- Vectoring in_x=10000, in_y=10000, in_z=0:
  - out_x=23289±8, out_y=0±4, out_z=8192±4.
- Quadrant cases:
  - Rotation in_x=19898, in_y=0, in_z=16384 gives out_x=0±4, out_y=32768±4 (no wrap in 18-bit output).
  - Vectoring in_x=-10000, in_y=0, in_z=0 gives out_z=-32768±4 (pi), out_x=16468±8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid:
  - outputs and out_valid stable; in_ready=0 throughout; done high only on the first cycle;
  - in_ready=1 the cycle after the handshake.
- abort at iter_cnt=7:
  - IDLE next cycle, out_valid never asserted, no done;
  - a following operand gives the correct result at normal latency.
- rst asserted mid-RUN simultaneously with abort: all outputs at reset values next cycle; back-to-back operands after reset each complete in ITERS+1 cycles.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// Includes an integer-only arctan generator used to build the angle table.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } cordic_state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // round(pi * 2^30)
  localparam longint PiFx = 64'sd3373259426;

  // round(atan(2^-i)/pi * 2^(data_w-1)); Taylor series in Q30, valid for data_w <= 32.
  function automatic logic [31:0] atan_const(input int unsigned data_w, input int unsigned i);
    longint acc;
    longint term;
    int     sh;
    acc = 0;
    if (i == 0) begin
      acc = longint'(64'd1 << (data_w - 3));
    end else begin
      for (int n = 0; n < 32; n++) begin
        sh = 30 - int'(i) * (2 * n + 1);
        if (sh >= 0) begin
          term = (longint'(1) << sh) / longint'(2 * n + 1);
          acc  = (n % 2 == 0) ? acc + term : acc - term;
        end
      end
      acc = ((acc << (data_w - 1)) + PiFx / 2) / PiFx;
    end
    return 32'(acc);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctan table, one entry per micro-rotation, built at elaboration.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ITERS  = 16,
  parameter int unsigned IDX_W  = $clog2(ITERS)
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] atan
);

  logic [DATA_W-1:0] atan_tab [ITERS];

  for (genvar g = 0; g < ITERS; g++) begin : g_tab
    localparam logic [31:0] Val = atan_const(DATA_W, g);
    assign atan_tab[g] = Val[DATA_W-1:0];
  end

  assign atan = (32'(idx) < ITERS) ? atan_tab[idx] : '0;

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC core: one micro-rotation per clock, rotation and vectoring modes,
// quadrant pre-rotation on accept, valid/ready on both sides.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ITERS  = 16,
  parameter int unsigned GUARD  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic signed [DATA_W-1:0]   in_x,
  input  logic signed [DATA_W-1:0]   in_y,
  input  logic signed [DATA_W-1:0]   in_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W+GUARD-1:0] out_x,
  output logic signed [DATA_W+GUARD-1:0] out_y,
  output logic signed [DATA_W-1:0]   out_z,
  output logic                       busy,
  output logic [$clog2(ITERS)-1:0]   iter_cnt,
  output logic                       done
);

  localparam int unsigned XW = DATA_W + GUARD;
  localparam int unsigned CW = $clog2(ITERS);
  localparam logic [DATA_W-1:0] Quarter  = {2'b01, {(DATA_W - 2){1'b0}}};
  localparam logic [CW-1:0]     LastIter = CW'(ITERS - 1);

  cordic_state_t state_q, state_d;
  logic                     mode_q, mode_d;
  logic signed [XW-1:0]     x_q, x_d, y_q, y_d;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic signed [XW-1:0]     res_x_q, res_x_d, res_y_q, res_y_d;
  logic signed [DATA_W-1:0] res_z_q, res_z_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d, done_q, done_d;

  logic signed [XW-1:0]     xe, ye, xs, ys, x_it, y_it;
  logic signed [DATA_W-1:0] z_it;
  logic [DATA_W-1:0]        atan;
  logic                     dir_pos;

  assign xe = {{GUARD{in_x[DATA_W-1]}}, in_x};
  assign ye = {{GUARD{in_y[DATA_W-1]}}, in_y};

  cordic_atan_rom #(
    .DATA_W(DATA_W),
    .ITERS (ITERS)
  ) u_atan_rom (
    .idx (cnt_q),
    .atan(atan)
  );

  // dir_pos means d = +1: rotation drives z to zero, vectoring drives y to zero.
  always_comb begin
    dir_pos = (mode_q == MODE_VEC) ? y_q[XW-1] : ~z_q[DATA_W-1];
    xs      = x_q >>> cnt_q;
    ys      = y_q >>> cnt_q;
    x_it    = dir_pos ? x_q - ys : x_q + ys;
    y_it    = dir_pos ? y_q + xs : y_q - xs;
    z_it    = dir_pos ? z_q - atan : z_q + atan;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_z_d     = res_z_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          mode_d  = in_mode;
          state_d = RUN;
          cnt_d   = '0;
          x_d     = xe;
          y_d     = ye;
          z_d     = in_z;
          if (in_mode == MODE_ROT) begin
            case (in_z[DATA_W-1 -: 2])
              2'b01: begin x_d = -ye; y_d = xe;  z_d = in_z - Quarter; end
              2'b10: begin x_d = ye;  y_d = -xe; z_d = in_z + Quarter; end
              default: ;
            endcase
          end else if (in_x[DATA_W-1]) begin
            if (!in_y[DATA_W-1]) begin
              x_d = ye;  y_d = -xe; z_d = in_z + Quarter;
            end else begin
              x_d = -ye; y_d = xe;  z_d = in_z - Quarter;
            end
          end
        end
      end
      RUN: begin
        x_d = x_it;
        y_d = y_it;
        z_d = z_it;
        if (cnt_q == LastIter) begin
          state_d     = HOLD;
          cnt_d       = '0;
          res_x_d     = x_it;
          res_y_d     = y_it;
          res_z_d     = z_it;
          out_valid_d = 1'b1;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      res_x_d     = res_x_q;
      res_y_d     = res_y_q;
      res_z_d     = res_z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_ROT;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_z_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_z_q     <= res_z_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign iter_cnt  = cnt_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_x     = res_x_q;
  assign out_y     = res_y_q;
  assign out_z     = res_z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: directed operands with hand-computed results,
// a monitor that checks latency, done pulses and result values on each output handshake.
module tb_cordic_iter_engine;

  localparam int DW = 16;
  localparam int IT = 16;
  localparam int GD = 2;
  localparam int XW = DW + GD;
  localparam int CW = $clog2(IT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DW-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic in_ready, out_valid, busy, done;
  logic signed [XW-1:0] out_x, out_y;
  logic signed [DW-1:0] out_z;
  logic [CW-1:0] iter_cnt;

  cordic_iter_engine #(.DATA_W(DW), .ITERS(IT), .GUARD(GD)) dut (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_z     (in_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_z    (out_z),
    .busy     (busy),
    .iter_cnt (iter_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int ex, ey, ez;
    int tx, ty, tz;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int req, input int diff,
                         input int tol);
    n_tests++;
    if (diff > tol || diff < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, req, tol);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic signed [DW-1:0] dz;
    if (rst || abort) begin
      done_cnt = 0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (done) begin
        done_cnt++;
        chk("latency", cyc - acc_cyc, IT + 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got out_valid, want none");
        end else begin
          e = sb.pop_front();
          dz = out_z - DW'(e.ez);
          chk_tol({e.name, "_x"}, int'(out_x), e.ex, int'(out_x) - e.ex, e.tx);
          chk_tol({e.name, "_y"}, int'(out_y), e.ey, int'(out_y) - e.ey, e.ty);
          chk_tol({e.name, "_z"}, int'(out_z), e.ez, int'(dz), e.tz);
          chk({e.name, "_done_pulses"}, done_cnt, 1);
        end
        done_cnt = 0;
      end
    end
  end

  task automatic expect_res(input string name, input int ex, input int ey, input int ez,
                            input int tx, input int ty, input int tz);
    exp_t e;
    e.name = name; e.ex = ex; e.ey = ey; e.ez = ez; e.tx = tx; e.ty = ty; e.tz = tz;
    sb.push_back(e);
  endtask

  task automatic send(input logic mode, input int x, input int y, input int z);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_mode  = mode;
    in_x     = DW'(x);
    in_y     = DW'(y);
    in_z     = DW'(z);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0, want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic wait_iter(input int k);
    int n;
    n = 0;
    while (!(busy && int'(iter_cnt) == k) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL iter_timeout: got iter_cnt=%0d, want %0d", iter_cnt, k);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_iter_cnt"}, int'(iter_cnt), 0);
    chk({tag, "_out_x"}, int'(out_x), 0);
    chk({tag, "_out_y"}, int'(out_y), 0);
    chk({tag, "_out_z"}, int'(out_z), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic signed [XW-1:0] fx, fy;
    logic signed [DW-1:0] fz;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Main function and quadrant boundaries.
    expect_res("rot_pi4", 23170, 23170, 0, 4, 4, 2);
    send(1'b0, 19898, 0, 8192);
    wait_drain();
    expect_res("vec_45", 23289, 0, 8192, 8, 4, 4);
    send(1'b1, 10000, 10000, 0);
    wait_drain();
    expect_res("rot_pi2", 0, 32768, 0, 4, 4, 4);
    send(1'b0, 19898, 0, 16384);
    wait_drain();
    expect_res("vec_pi", 16468, 0, -32768, 8, 4, 4);
    send(1'b1, -10000, 0, 0);
    wait_drain();
    expect_res("rot_mpi", -32768, 0, 0, 4, 4, 4);
    send(1'b0, 19898, 0, -32768);
    wait_drain();
    expect_res("rot_mpi4", 23170, -23170, 0, 4, 4, 4);
    send(1'b0, 19898, 0, -8192);
    wait_drain();

    // Backpressure: hold out_ready low for 5 cycles of out_valid.
    @(posedge clk); #1;
    out_ready = 1'b0;
    expect_res("bp", 23170, 23170, 0, 4, 4, 2);
    send(1'b0, 19898, 0, 8192);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_done_first", int'(done), 1);
    chk("bp_in_ready0", int'(in_ready), 0);
    fx = out_x; fy = out_y; fz = out_z;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_done", int'(done), 0);
      chk("bp_hold_in_ready", int'(in_ready), 0);
      chk("bp_hold_x", int'(out_x), int'(fx));
      chk("bp_hold_y", int'(out_y), int'(fy));
      chk("bp_hold_z", int'(out_z), int'(fz));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", int'(in_ready), 1);
    chk("bp_valid_after", int'(out_valid), 0);

    // Abort at iteration 7: result discarded.
    send(1'b0, 19898, 0, 8192);
    wait_iter(7);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_iter_cnt", int'(iter_cnt), 0);
    chk("abort_valid", int'(out_valid), 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || done) seen = 1;
    end
    chk("abort_no_result", seen, 0);

    // Abort in IDLE swallows a same-cycle operand.
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = 1'b0; in_x = 16'sd19898; in_y = '0; in_z = 16'sd8192;
    abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", int'(busy), 0);

    expect_res("post_abort", 23289, 0, 8192, 8, 4, 4);
    send(1'b1, 10000, 10000, 0);
    wait_drain();

    // rst together with abort mid-RUN, then back-to-back operands.
    send(1'b0, 19898, 0, 16384);
    wait_iter(5);
    rst = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    reset_checks("rst_abort");
    expect_res("b2b_a", 23170, 23170, 0, 4, 4, 2);
    expect_res("b2b_b", 16468, 0, -32768, 8, 4, 4);
    send(1'b0, 19898, 0, 8192);
    send(1'b1, -10000, 0, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
